// File: rtl/tx_pkg.sv
// tx_pkg: state/error types and register address map shared by the RX frame
// decoder and the data memory it feeds.
package tx_pkg;
  typedef enum logic [2:0] {HUNT, ADDR, PAYLOAD, CSUM, BURST} rx_state_t;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ADDR    = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;
  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] REG1 = 8'h00;
  localparam logic [7:0] REG2 = 8'h02;
  localparam logic [7:0] REG3 = 8'h04;
  localparam logic [7:0] REG4 = 8'h06;
  localparam logic [7:0] REG5 = 8'h08;
  localparam logic [7:0] REG6 = 8'h0A;
  localparam logic [7:0] REG7 = 8'h0C;
  localparam logic [7:0] REG8 = 8'h0E;
endpackage

// File: rtl/rx_frame_decoder_if.sv
// rx_frame_decoder_if: UART byte input and memory write-burst output of the decoder.
interface rx_frame_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  import tx_pkg::*;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_enabl;
  logic                  frame_done;
  logic                  frame_err;
  err_code_t             err_code;
  logic                  overrun;
  modport master (
    output rx_data, rx_valid,
    input  wr_data, wr_addr, wr_enabl, frame_done, frame_err, err_code, overrun
  );
  modport slave (
    input  rx_data, rx_valid,
    output wr_data, wr_addr, wr_enabl, frame_done, frame_err, err_code, overrun
  );
endinterface

// File: rtl/frame_payload_buf.sv
// frame_payload_buf: SIZE-entry payload store with auto-incrementing write and
// read pointers; both pointers clear together at frame start.
module frame_payload_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_wr_last,
  output logic                  o_rd_done
);
  localparam int PW = $clog2(SIZE + 1);
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= i_we ? r_wptr + 1'b1 : r_wptr;
      r_rptr <= i_re ? r_rptr + 1'b1 : r_rptr;
    end
  // Payload contents are fully rewritten by every frame, so no reset is needed.
  always_ff @(posedge i_clk)
    if (i_we) r_mem[r_wptr[IW-1:0]] <= i_wdata;
  assign o_rdata   = r_rptr < PW'(SIZE) ? r_mem[r_rptr[IW-1:0]] : '0;
  assign o_wr_last = r_wptr == PW'(SIZE - 1);
  assign o_rd_done = r_rptr == PW'(SIZE);
endmodule

// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: parses SOF/ADDR/payload/XOR-checksum frames from the RX byte
// stream and replays a valid payload as one gap-free SIZE-cycle write burst.
module rx_frame_decoder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    SIZE        = 10,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = DATA_WIDTH'(tx_pkg::SOF_BYTE),
  parameter int                    TIMEOUT_CYC = 100000
) (
  input logic               clk_in,
  input logic               rst_n_in,
  rx_frame_decoder_if.slave bus
);
  import tx_pkg::*;
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  rx_state_t             r_state, w_state;
  err_code_t             r_err_code, w_err_code;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr, r_wr_addr, w_wr_addr;
  logic [DATA_WIDTH-1:0] r_csum, w_csum, r_wr_data, w_wr_data;
  logic [TW-1:0]         r_tmo, w_tmo;
  logic                  r_wr_en, w_wr_en, r_done, w_done, r_err, w_err, r_ovr, w_ovr;
  logic                  w_we, w_re, w_clr, w_wr_last, w_rd_done;
  logic                  w_in_frame, w_expired, w_addr_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;
  frame_payload_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) u_buf (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n_in),
    .i_clr     (w_clr),
    .i_we      (w_we),
    .i_wdata   (bus.rx_data),
    .i_re      (w_re),
    .o_rdata   (w_rd_data),
    .o_wr_last (w_wr_last),
    .o_rd_done (w_rd_done)
  );
  assign w_in_frame = r_state inside {ADDR, PAYLOAD, CSUM};
  // A byte arriving on the expiry cycle is processed instead of timing out.
  assign w_expired  = w_in_frame && !bus.rx_valid && r_tmo == TMO_LAST;
  assign w_addr_ok  = bus.rx_data < DATA_WIDTH'(16) && !bus.rx_data[0];
  assign w_tmo      = (bus.rx_valid || !w_in_frame) ? '0 : (&r_tmo ? r_tmo : r_tmo + 1'b1);
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_csum     = r_csum;
    w_wr_en    = 1'b0;
    w_wr_data  = r_wr_data;
    w_wr_addr  = r_wr_addr;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_err_code = r_err_code;
    w_ovr      = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_clr      = 1'b0;
    unique case (r_state)
      HUNT: if (bus.rx_valid && bus.rx_data == SOF_BYTE) begin
        w_state = ADDR;
        w_clr   = 1'b1;
      end
      ADDR: if (bus.rx_valid) begin
        w_state    = w_addr_ok ? PAYLOAD : HUNT;
        w_addr     = w_addr_ok ? bus.rx_data[ADDR_WIDTH-1:0] : r_addr;
        w_csum     = bus.rx_data;
        w_err      = !w_addr_ok;
        w_err_code = w_addr_ok ? r_err_code : ERR_ADDR;
      end
      PAYLOAD: if (bus.rx_valid) begin
        w_state = w_wr_last ? CSUM : PAYLOAD;
        w_csum  = r_csum ^ bus.rx_data;
        w_we    = 1'b1;
      end
      CSUM: if (bus.rx_valid) begin
        if (bus.rx_data == r_csum) begin
          // Preload the first beat so the burst starts the cycle after the checksum.
          w_state   = BURST;
          w_re      = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_data = w_rd_data;
          w_wr_addr = r_addr;
        end else begin
          w_state    = HUNT;
          w_err      = 1'b1;
          w_err_code = ERR_CSUM;
        end
      end
      BURST: begin
        w_ovr     = bus.rx_valid;
        w_state   = w_rd_done ? HUNT : BURST;
        w_done    = w_rd_done;
        w_re      = !w_rd_done;
        w_wr_en   = !w_rd_done;
        w_wr_data = w_rd_done ? r_wr_data : w_rd_data;
        w_wr_addr = w_rd_done ? r_wr_addr : r_addr;
      end
      default: w_state = HUNT;
    endcase
    if (w_expired) begin
      w_state    = HUNT;
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state    <= HUNT;
      r_err_code <= ERR_NONE;
      r_addr     <= '0;
      r_wr_addr  <= '0;
      r_csum     <= '0;
      r_wr_data  <= '0;
      r_tmo      <= '0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_err_code <= w_err_code;
      r_addr     <= w_addr;
      r_wr_addr  <= w_wr_addr;
      r_csum     <= w_csum;
      r_wr_data  <= w_wr_data;
      r_tmo      <= w_tmo;
      r_wr_en    <= w_wr_en;
      r_done     <= w_done;
      r_err      <= w_err;
      r_ovr      <= w_ovr;
    end
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_enabl   = r_wr_en;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb_rx_frame_decoder: scoreboard bench; expected writes and frame events are
// queued as frames are sent and popped as the decoder produces them.
module tb_rx_frame_decoder;
  localparam int SIZE = 10;
  localparam int EV_DONE = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  int run = 0;
  int ovr_seen = 0;
  int ev;
  logic prev_en = 1'b0;
  logic [11:0] e;
  logic [11:0] wq[$];
  int eq[$];
  logic [7:0] pl [SIZE];
  logic [7:0] pr [SIZE];
  rx_frame_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  rx_frame_decoder #(.SIZE(SIZE), .TIMEOUT_CYC(16)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] a, input logic [7:0] p [SIZE], input bit bad);
    logic [7:0] c;
    c = a;
    for (int i = 0; i < SIZE; i++) c ^= p[i];
    if (bad) c ^= 8'h0F;
    if (bad) eq.push_back(2);
    else begin
      for (int i = 0; i < SIZE; i++) wq.push_back({a[3:0], p[i]});
      eq.push_back(EV_DONE);
    end
    send_byte(8'hA5);
    send_byte(a);
    for (int i = 0; i < SIZE; i++) send_byte(p[i]);
    send_byte(c);
    if (bad) begin
      chk("csum_err_pulse", bus.frame_err, 1);
      chk("csum_err_code", bus.err_code, 2);
    end else chk("burst_start", bus.wr_enabl, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && (wq.size() != 0 || eq.size() != 0); i++) tick();
    chk("drain", wq.size() + eq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      prev_en = 1'b0;
    end else begin
      if (bus.wr_enabl) begin
        run++;
        chk("wr_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("wr_addr", bus.wr_addr, e[11:8]);
          chk("wr_data", bus.wr_data, e[7:0]);
        end
      end else if (run != 0) begin
        chk("burst_len", run, SIZE);
        run = 0;
      end
      if (bus.frame_done || bus.frame_err) begin
        ev = bus.frame_done ? EV_DONE : int'(bus.err_code);
        chk("done_err_excl", bus.frame_done & bus.frame_err, 0);
        if (bus.frame_done) chk("done_after_burst", prev_en, 1);
        chk("evt_expected", eq.size() != 0, 1);
        if (eq.size() != 0) chk("event", ev, eq.pop_front());
      end
      if (bus.overrun) ovr_seen++;
      prev_en = bus.wr_enabl;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_wr_enabl", bus.wr_enabl, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < SIZE; i++) pl[i] = 8'(i + 1);
    send_frame(8'h04, pl, 0);
    wait_idle();
    send_frame(8'h04, pl, 1);
    wait_idle();
    eq.push_back(1);
    send_byte(8'hA5);
    send_byte(8'h05);
    chk("addr_err_pulse", bus.frame_err, 1);
    chk("addr_err_code", bus.err_code, 1);
    for (int i = 0; i < SIZE; i++) send_byte(pl[i]);
    send_byte(8'h0F);
    wait_idle();
    eq.push_back(3);
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    repeat (15) tick();
    chk("tmo_early", bus.frame_err, 0);
    tick();
    chk("tmo_pulse", bus.frame_err, 1);
    chk("tmo_code", bus.err_code, 3);
    wait_idle();
    send_frame(8'h04, pl, 0);
    wait_idle();
    chk("err_hold", bus.err_code, 3);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    for (int i = 0; i < SIZE; i++) pr[i] = 8'($urandom);
    pr[3] = 8'hA5;
    send_frame(8'h0E, pr, 0);
    repeat (3) tick();
    send_byte(8'h33);
    chk("overrun_pulse", bus.overrun, 1);
    wait_idle();
    for (int i = 0; i < SIZE; i++) pr[i] = 8'($urandom);
    send_frame(8'h00, pr, 0);
    wait_idle();
    send_frame(8'h08, pl, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_enabl", bus.wr_enabl, 0);
    wq.delete();
    eq.delete();
    repeat (3) tick();
    chk("rst_mid_err_code", bus.err_code, 0);
    chk("rst_mid_no_done", bus.frame_done, 0);
    rst_n = 1'b1;
    repeat (SIZE + 2) tick();
    send_frame(8'h06, pl, 0);
    wait_idle();
    chk("overrun_count", ovr_seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
